alu_serial: RTL
===============

Name: alu_serial

Overview:
- Parametrised digit-serial integer ALU; successor to the 1-bit ALU slice.
- Processes a WIDTH-bit operation DIGIT bits per clock, LSB digit first, through one internal DIGIT-wide slice with a registered carry.
- Adds a valid/ready handshake, signed and unsigned set-less-than, and status flags.
- Sits beside the execute stage as an area-reduced ALU for multi-cycle ops.

Parameters:
- WIDTH, 32, operand/result width in bits.
- DIGIT, 4, bits processed per RUN cycle. WIDTH % DIGIT must be 0 and DIGIT <= WIDTH, else elaboration error.
- N = WIDTH/DIGIT is derived (localparam), not a parameter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operation request
- in_ready  output  1  block can accept; = (state==IDLE)
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- op  input  3  {binv, sel[1:0]}
- out_valid  output  1  result valid; = (state==DONE)
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  registered result
- zero, ovf, cout  output  1 each  flags; present only with ALU_SERIAL_FLAGS_EN

Behaviour:
- Reset (rst_n low, async):
  - State goes to IDLE; result=0; digit counter=0; carry=0.
  - out_valid=0; in_ready=1; flags=0.
  - Inputs are ignored while rst_n is low. Reset mid-RUN or in DONE abandons the operation with no output.
- States:
  - IDLE: in_valid && in_ready captures a, b, op into shadow registers -> RUN. Carry is initialised to binv (1 for subtract/compare).
  - RUN: digit k (k = 0..N-1) is processed at the k-th RUN clock edge. At edge N-1 -> DONE.
  - DONE: holds result and flags stable until out_ready=1 -> IDLE.
- Latency and throughput:
  - out_valid rises exactly N cycles after the accept edge (8 for the defaults).
  - One operation per N+2 cycles at best. in_ready=0 in RUN and DONE; in_valid there has no effect.
- Op encoding:
  - 000 AND, 001 OR, 010 ADD: a + b.
  - 110 SUB: a + ~b + 1.
  - 111 SLTU: result = {0, (a <u b)}.
  - 011 SLT (signed): result = {0, (a <s b)}. sel=11 always subtracts; binv selects signed (0) or unsigned (1) compare.
  - 1xx with sel = 00/01: AND/OR with ~b.
- Arithmetic:
  - Each digit uses carry in from the previous digit; the final carry is kept as cout.
  - ovf = carry into MSB xor carry out of MSB.
  - Signed less = sum[MSB] xor ovf. Unsigned less = ~cout (borrow).
  - For SLT/SLTU, the result is all zeros with bit0 = less, written on the transition into DONE. Intermediate sum digits are not visible.
- Wrap-around: sums wrap mod 2^WIDTH; no saturation.
- Simultaneous events: out_ready high on the DONE entry cycle -> IDLE on the next edge. in_valid asserted in that same DONE cycle is not accepted; it must remain held into IDLE.
- DIGIT == WIDTH is legal: a single RUN cycle, out_valid 1 cycle after accept.

Optional Feature:
- Macro: ALU_SERIAL_FLAGS_EN.
- Defined:
  - Ports zero, ovf and cout exist and are registered, updated on entry to DONE, stable through DONE.
  - zero = (result==0).
  - ovf and cout are meaningful for ADD/SUB/SLT/SLTU; forced 0 for AND/OR.
  - Reset value is 0.
- Undefined: the flag ports and registers are absent; all other behaviour is identical.

Test Plan (WIDTH=32, DIGIT=4):
- ADD 0x7FFFFFFF + 0x00000001 -> result 0x80000000, ovf=1, cout=0, zero=0. out_valid high exactly 8 cycles after the accept edge.
- SUB 5 - 7 -> 0xFFFFFFFE, cout=0. SUB 7 - 7 -> 0x00000000, zero=1, cout=1.
- a=0xFFFFFFFF, b=0x00000001: SLT (011) -> 0x00000001; SLTU (111) -> 0x00000000.
- AND / OR with a=0xF0F0F0F0, b=0x0FF00FF0 -> 0x00F000F0 / 0xFFF0FFF0. op 100 (AND ~b) -> 0xF000F000.
- Backpressure: out_ready low 5 cycles in DONE -> result and flags stable, in_ready=0, a second in_valid is not accepted. After out_ready: IDLE, then accepts the pending request.
- Assert rst_n low at RUN digit 3 -> out_valid=0, result=0, in_ready=1 immediately. A new ADD 1+1 after release returns 0x00000002.

Source files
------------

// File: rtl/alu_serial.sv
// Digit-serial integer ALU: WIDTH-bit AND/OR/ADD/SUB/SLT/SLTU processed DIGIT bits per clock.
// Optional registered zero/ovf/cout flag ports are enabled by defining ALU_SERIAL_FLAGS_EN.
module alu_serial #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result
`ifdef ALU_SERIAL_FLAGS_EN
    ,
    output logic             zero,
    output logic             ovf,
    output logic             cout
`endif
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_digit
        $error("alu_serial: DIGIT must divide WIDTH and satisfy 1 <= DIGIT <= WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             cout_q, cout_d;

    logic             sub_s;
    logic [DIGIT-1:0] a_dig_s;
    logic [DIGIT-1:0] b_dig_s;
    logic [DIGIT:0]   sum_s;
    logic             c_msb_s;
    logic [DIGIT-1:0] dig_res_s;
    logic [WIDTH-1:0] acc_next_s;
    logic             ovf_s;
    logic             less_s;
    logic             last_s;
    logic [WIDTH-1:0] final_s;

    // Digit slice: one DIGIT-wide adder/logic unit fed from the low digit of the shadow operands
    always_comb begin
        sub_s     = op_q[2] | (op_q[1:0] == 2'b11);
        a_dig_s   = a_q[DIGIT-1:0];
        b_dig_s   = sub_s ? ~b_q[DIGIT-1:0] : b_q[DIGIT-1:0];
        sum_s     = {1'b0, a_dig_s} + {1'b0, b_dig_s} + {{DIGIT{1'b0}}, carry_q};
        // Carry into the top bit of the digit, recovered from the sum bit
        c_msb_s   = sum_s[DIGIT-1] ^ a_dig_s[DIGIT-1] ^ b_dig_s[DIGIT-1];
        ovf_s     = sum_s[DIGIT] ^ c_msb_s;
        case (op_q[1:0])
            2'b00:   dig_res_s = a_dig_s & b_dig_s;
            2'b01:   dig_res_s = a_dig_s | b_dig_s;
            default: dig_res_s = sum_s[DIGIT-1:0];
        endcase
        acc_next_s = (acc_q >> DIGIT) | (WIDTH'(dig_res_s) << (WIDTH - DIGIT));
        less_s     = op_q[2] ? ~sum_s[DIGIT] : (acc_next_s[WIDTH-1] ^ ovf_s);
        if (op_q[1:0] == 2'b11) begin
            final_s = WIDTH'(less_s);
        end else begin
            final_s = acc_next_s;
        end
        last_s = (cnt_q == CW'(N - 1));
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid) state_d = RUN;
                else          state_d = IDLE;
            end
            RUN: begin
                if (last_s) state_d = DONE;
                else        state_d = RUN;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
                else           state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: capture on accept, shift one digit per RUN cycle, commit on the last digit
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        cout_d   = cout_q;
        if (state_q == IDLE && in_valid) begin
            a_d     = a;
            b_d     = b;
            op_d    = op;
            carry_d = op[2] | (op[1:0] == 2'b11);
            cnt_d   = {CW{1'b0}};
            acc_d   = {WIDTH{1'b0}};
        end else if (state_q == RUN) begin
            a_d     = a_q >> DIGIT;
            b_d     = b_q >> DIGIT;
            carry_d = sum_s[DIGIT];
            cnt_d   = cnt_q + CW'(1);
            acc_d   = acc_next_s;
            if (last_s) begin
                result_d = final_s;
                zero_d   = (final_s == {WIDTH{1'b0}});
                ovf_d    = op_q[1] ? ovf_s : 1'b0;
                cout_d   = op_q[1] ? sum_s[DIGIT] : 1'b0;
            end else begin
                result_d = result_q;
            end
        end else begin
            a_d = a_q;
        end
    end

    // Handshake outputs follow the next state so they come straight from flops
    always_comb begin
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= {WIDTH{1'b0}};
            b_q         <= {WIDTH{1'b0}};
            op_q        <= 3'b000;
            carry_q     <= 1'b0;
            cnt_q       <= {CW{1'b0}};
            acc_q       <= {WIDTH{1'b0}};
            result_q    <= {WIDTH{1'b0}};
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            cout_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
            cout_q      <= cout_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
`ifdef ALU_SERIAL_FLAGS_EN
    assign zero = zero_q;
    assign ovf  = ovf_q;
    assign cout = cout_q;
`else
    logic unused_flags_s;
    assign unused_flags_s = zero_q ^ ovf_q ^ cout_q;
`endif

endmodule
